life_engine: RTL and testbench

Sequential Game of Life generation engine for the VGA demoscene top level. It holds the 16×16 cell grid and advances it one generation every `FRAMES_PER_GEN` frames. It serially scans one cell per clock, then commits the new generation in a single cycle. The pixel renderer reads the displayed grid through a combinational read port addressed by its current cell coordinate.

---
 rtl/life_pkg.sv | 30 +++
 rtl/life_if.sv | 34 +++
 rtl/life_rule.sv | 27 ++
 rtl/life_engine.sv | 151 +++++++++++++++
 tb/tb_life_engine.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/life_pkg.sv
// -----------------------------------------------------------------------------
// life_pkg
// Shared definitions for the Game of Life generation engine: grid geometry,
// the engine state encoding and the default 16x16 seed pattern.
// Grid bit index is y*16+x; each 16-bit row below is listed from row 15
// down to row 0, with bit 0 of a row being column x=0.
// -----------------------------------------------------------------------------
package life_pkg;

    localparam int unsigned GRID_W     = 16;
    localparam int unsigned GRID_H     = 16;
    localparam int unsigned GRID_CELLS = GRID_W * GRID_H;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } life_state_t;

    // Default seed: a lone cell at (3,0) plus a glider in the upper-left area.
    localparam logic [GRID_CELLS-1:0] SEED_UWE = {
        {11{16'h0000}},  // rows 15..5
        16'h0007,        // row 4: (0,4) (1,4) (2,4)
        16'h0004,        // row 3: (2,3)
        16'h0002,        // row 2: (1,2)
        16'h0000,        // row 1
        16'h0008         // row 0: (3,0)
    };

endpackage

// File: rtl/life_if.sv
// -----------------------------------------------------------------------------
// life_if
// Control and read-port bundle between the demoscene top level (master) and
// the life engine (slave).
//   frame_tick  : one-cycle pulse per frame
//   pause       : freezes frame counting and generation start
//   reseed      : one-cycle pulse, reloads the seed pattern
//   rd_x, rd_y  : renderer cell coordinate
//   rd_cell     : displayed state of (rd_x, rd_y), combinational
//   busy        : a generation is being computed or committed
//   gen_count   : generations committed since reset or reseed
// -----------------------------------------------------------------------------
interface life_if;

    logic        frame_tick;
    logic        pause;
    logic        reseed;
    logic [3:0]  rd_x;
    logic [3:0]  rd_y;
    logic        rd_cell;
    logic        busy;
    logic [15:0] gen_count;

    modport master (
        output frame_tick, pause, reseed, rd_x, rd_y,
        input  rd_cell, busy, gen_count
    );

    modport slave (
        input  frame_tick, pause, reseed, rd_x, rd_y,
        output rd_cell, busy, gen_count
    );

endinterface

// File: rtl/life_rule.sv
// -----------------------------------------------------------------------------
// life_rule
// Combinational B3/S23 rule for a single cell.
//   nbr    : the 8 neighbour states (out-of-grid neighbours already forced dead)
//   centre : current state of the cell
//   next   : state of the cell in the next generation
// -----------------------------------------------------------------------------
module life_rule (
    input  logic [7:0] nbr,
    input  logic       centre,
    output logic       next
);

    logic [3:0] cnt;

    always_comb begin
        // NOTE: give every always_comb variable a value before any loop or
        // branch, otherwise synthesis infers a latch to hold the old value.
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, nbr[i]};
        end
    end

    assign next = (cnt == 4'd3) | (centre & (cnt == 4'd2));

endmodule

// File: rtl/life_engine.sv
// -----------------------------------------------------------------------------
// life_engine
// Sequential Game of Life engine for a 16x16 grid. Every FRAMES_PER_GEN
// un-paused frame ticks it scans all 256 cells (one per clock) into a scratch
// grid, then commits the scratch grid to the displayed grid in one cycle, so
// the renderer never sees a partially computed generation.
//
// Parameters:
//   FRAMES_PER_GEN : frame ticks per generation (>= 1)
//   SEED           : initial grid, bit index y*16+x
// Ports:
//   clk, rst_n     : pixel clock, asynchronous active-low reset
//   bus            : life_if.slave (frame_tick, pause, reseed, rd_x, rd_y in;
//                    rd_cell, busy, gen_count out)
// Build option:
//   LIFE_WRAP_EN   : when defined the grid is toroidal; otherwise cells
//                    outside the grid count as dead.
// -----------------------------------------------------------------------------
module life_engine
    import life_pkg::*;
#(
    parameter int unsigned            FRAMES_PER_GEN = 60,
    parameter logic [GRID_CELLS-1:0]  SEED           = SEED_UWE
) (
    input  logic   clk,
    input  logic   rst_n,
    life_if.slave  bus
);

    localparam int unsigned FW = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;
    localparam logic [FW-1:0] FCNT_LAST = FW'(FRAMES_PER_GEN - 1);

    life_state_t           state;
    logic [7:0]            idx;
    logic [GRID_CELLS-1:0] cur;
    logic [GRID_CELLS-1:0] nxt;
    logic [FW-1:0]         fcnt;
    logic                  busy_q;
    logic [15:0]           gen_q;

    // Generation request: the tick that wraps the frame counter.
    logic gen_req;
    assign gen_req = bus.frame_tick & ~bus.pause & (fcnt == FCNT_LAST);

    // ---------------------------------------------------------------------
    // Neighbour gathering for the cell under the scan index.
    // ---------------------------------------------------------------------
    logic [3:0] x, y, xm, xp, ym, yp;
    logic       xm_ok, xp_ok, ym_ok, yp_ok;
    logic [7:0] nbr;
    logic       next_cell;

    assign x  = idx[3:0];
    assign y  = idx[7:4];
    // 4-bit arithmetic wraps naturally, which is exactly the toroidal case.
    assign xm = x - 4'd1;
    assign xp = x + 4'd1;
    assign ym = y - 4'd1;
    assign yp = y + 4'd1;

`ifdef LIFE_WRAP_EN
    assign xm_ok = 1'b1;
    assign xp_ok = 1'b1;
    assign ym_ok = 1'b1;
    assign yp_ok = 1'b1;
`else
    assign xm_ok = (x != 4'd0);
    assign xp_ok = (x != 4'd15);
    assign ym_ok = (y != 4'd0);
    assign yp_ok = (y != 4'd15);
`endif

    assign nbr[0] = ym_ok & xm_ok & cur[{ym, xm}];
    assign nbr[1] = ym_ok &         cur[{ym, x }];
    assign nbr[2] = ym_ok & xp_ok & cur[{ym, xp}];
    assign nbr[3] =         xm_ok & cur[{y,  xm}];
    assign nbr[4] =         xp_ok & cur[{y,  xp}];
    assign nbr[5] = yp_ok & xm_ok & cur[{yp, xm}];
    assign nbr[6] = yp_ok &         cur[{yp, x }];
    assign nbr[7] = yp_ok & xp_ok & cur[{yp, xp}];

    life_rule u_rule (
        .nbr    (nbr),
        .centre (cur[idx]),
        .next   (next_cell)
    );

    // ---------------------------------------------------------------------
    // Control FSM and grid storage.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: both grids are plain flops, not a RAM, so they take a
            // reset value; the displayed grid must come up as the seed.
            state  <= IDLE;
            idx    <= '0;
            cur    <= SEED;
            nxt    <= '0;
            fcnt   <= '0;
            busy_q <= 1'b0;
            gen_q  <= '0;
        end else if (bus.reseed) begin
            // Reseed overrides everything, including a same-cycle frame tick.
            state  <= IDLE;
            idx    <= '0;
            cur    <= SEED;
            nxt    <= '0;
            fcnt   <= '0;
            busy_q <= 1'b0;
            gen_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the values from before this edge, independent of statement order.
            if (bus.frame_tick && !bus.pause) begin
                fcnt <= (fcnt == FCNT_LAST) ? '0 : fcnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (gen_req) begin
                        state  <= SCAN;
                        idx    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                SCAN: begin
                    nxt[idx] <= next_cell;
                    idx      <= idx + 8'd1;
                    if (idx == 8'd255) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    cur    <= nxt;
                    gen_q  <= gen_q + 16'd1;
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_cell   = cur[{bus.rd_y, bus.rd_x}];
    assign bus.busy      = busy_q;
    assign bus.gen_count = gen_q;

endmodule

// File: tb/tb_life_engine.sv
// -----------------------------------------------------------------------------
// tb_life_engine
// Self-checking bench for life_engine. Four engines share clock, reset and
// the renderer coordinate:
//   0: defaults (FRAMES_PER_GEN=60, SEED_UWE)   - reset state
//   1: blinker, FRAMES_PER_GEN=1                - generations, pause, reseed
//   2: blinker, FRAMES_PER_GEN=3                - frame pacing, dropped request
//   3: edge row at y=0, FRAMES_PER_GEN=1        - grid boundary (LIFE_WRAP_EN)
// Expected grids are queued when a generation is started and compared when
// the engine drops busy.
// -----------------------------------------------------------------------------
module tb_life_engine;
    import life_pkg::*;

    localparam logic [255:0] BLINK = (256'd1 << 69) | (256'd1 << 85) | (256'd1 << 101);
    localparam logic [255:0] HORIZ = (256'd1 << 84) | (256'd1 << 85) | (256'd1 << 86);
    localparam logic [255:0] EDGE  = (256'd1 << 15) | (256'd1 << 0)  | (256'd1 << 1);
`ifdef LIFE_WRAP_EN
    localparam logic [255:0] EDGE_NEXT = (256'd1 << 240) | (256'd1 << 0) | (256'd1 << 16);
`else
    localparam logic [255:0] EDGE_NEXT = '0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] rx    = '0;
    logic [3:0] ry    = '0;
    logic [3:0] tick_v   = '0;
    logic [3:0] pause_v  = '0;
    logic [3:0] reseed_v = '0;

    logic [3:0]  busy_w;
    logic [3:0]  cell_w;
    logic [15:0] gen_w [4];

    always #5 clk = ~clk;

    life_if ifs[4] ();

    for (genvar k = 0; k < 4; k++) begin : g_bus
        assign ifs[k].frame_tick = tick_v[k];
        assign ifs[k].pause      = pause_v[k];
        assign ifs[k].reseed     = reseed_v[k];
        assign ifs[k].rd_x       = rx;
        assign ifs[k].rd_y       = ry;
        assign busy_w[k]         = ifs[k].busy;
        assign cell_w[k]         = ifs[k].rd_cell;
        assign gen_w[k]          = ifs[k].gen_count;
    end

    life_engine u_def (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifs[0])
    );

    life_engine #(.FRAMES_PER_GEN(1), .SEED(BLINK)) u_blk (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifs[1])
    );

    life_engine #(.FRAMES_PER_GEN(3), .SEED(BLINK)) u_pace (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifs[2])
    );

    life_engine #(.FRAMES_PER_GEN(1), .SEED(EDGE)) u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifs[3])
    );

    // ---------------------------------------------------------------------
    // Scoreboard and helpers
    // ---------------------------------------------------------------------
    typedef struct {
        int           inst;
        logic [255:0] grid;
        logic [15:0]  gen;
        string        tag;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           passed = 0;
    logic [255:0] g [4];

    // Reference B3/S23 step written over plain integer coordinates.
    function automatic logic [255:0] life_step(input logic [255:0] s, input bit wrap);
        logic [255:0] r;
        r = '0;
        for (int yy = 0; yy < 16; yy++) begin
            for (int xx = 0; xx < 16; xx++) begin
                int n;
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        int px, py;
                        if (dx == 0 && dy == 0) continue;
                        px = xx + dx;
                        py = yy + dy;
                        if (wrap) begin
                            px = (px + 16) % 16;
                            py = (py + 16) % 16;
                        end else if (px < 0 || px > 15 || py < 0 || py > 15) begin
                            continue;
                        end
                        if (s[py*16 + px]) n++;
                    end
                end
                r[yy*16 + xx] = (n == 3) || (s[yy*16 + xx] && n == 2);
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Sweep the renderer port of all four engines.
    task automatic read_grids();
        for (int yy = 0; yy < 16; yy++) begin
            for (int xx = 0; xx < 16; xx++) begin
                rx = 4'(xx);
                ry = 4'(yy);
                #1;
                for (int s = 0; s < 4; s++) g[s][yy*16 + xx] = cell_w[s];
            end
        end
    endtask

    task automatic tick(input int s);
        @(negedge clk);
        tick_v[s] = 1'b1;
        @(negedge clk);
        tick_v[s] = 1'b0;
    endtask

    task automatic wait_idle(input int s);
        int n;
        n = 0;
        while (busy_w[s] && n < 400) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("idle_timeout_%0d", s), 256'(busy_w[s]), 256'd0);
    endtask

    task automatic check_gen();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            $error("FAIL sb_empty: observed 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            read_grids();
            check({e.tag, "_grid"}, g[e.inst], e.grid);
            check({e.tag, "_gen"}, 256'(gen_w[e.inst]), 256'(e.gen));
        end
    endtask

    // ---------------------------------------------------------------------
    // Directed sequence
    // ---------------------------------------------------------------------
    initial begin
        int  bcount;
        logic first_busy;

        // Reset state
        repeat (2) @(negedge clk);
        read_grids();
        check("rst_busy", 256'(busy_w[0]), 256'd0);
        check("rst_gen", 256'(gen_w[0]), 256'd0);
        check("rst_cell_3_0", 256'(g[0][3]), 256'd1);
        check("rst_cell_0_0", 256'(g[0][0]), 256'd0);
        check("rst_grid_def", g[0], SEED_UWE);
        check("rst_grid_blk", g[1], BLINK);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Blinker: two generations
        sb.push_back('{1, HORIZ, 16'd1, "blink1"});
        tick(1);
        check("blink1_busy", 256'(busy_w[1]), 256'd1);
        wait_idle(1);
        check_gen();
        sb.push_back('{1, BLINK, 16'd2, "blink2"});
        tick(1);
        wait_idle(1);
        check_gen();

        // Pause freezes generation start
        pause_v[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check($sformatf("pause_busy_%0d", i), 256'(busy_w[1]), 256'd0);
        end
        pause_v[1] = 1'b0;
        read_grids();
        check("pause_grid", g[1], BLINK);
        check("pause_gen", 256'(gen_w[1]), 256'd2);

        // Third generation, then reseed mid-scan
        sb.push_back('{1, HORIZ, 16'd3, "blink3"});
        tick(1);
        wait_idle(1);
        check_gen();
        tick(1);
        repeat (99) @(negedge clk);
        check("rs_scan_busy", 256'(busy_w[1]), 256'd1);
        reseed_v[1] = 1'b1;
        tick_v[1]   = 1'b1;
        @(negedge clk);
        reseed_v[1] = 1'b0;
        tick_v[1]   = 1'b0;
        check("rs_busy", 256'(busy_w[1]), 256'd0);
        check("rs_gen", 256'(gen_w[1]), 256'd0);
        read_grids();
        check("rs_grid", g[1], BLINK);
        repeat (5) @(negedge clk);
        check("rs_nostart_busy", 256'(busy_w[1]), 256'd0);
        check("rs_nostart_gen", 256'(gen_w[1]), 256'd0);

        // Pacing with FRAMES_PER_GEN=3
        tick(2);
        check("pace_t1_busy", 256'(busy_w[2]), 256'd0);
        tick(2);
        check("pace_t2_busy", 256'(busy_w[2]), 256'd0);
        sb.push_back('{2, life_step(BLINK, 1'b0), 16'd1, "pace"});
        @(negedge clk);
        tick_v[2] = 1'b1;
        @(negedge clk);
        bcount     = 0;
        first_busy = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (cyc == 0) first_busy = busy_w[2];
            if (busy_w[2]) bcount++;
            tick_v[2] = (cyc == 10 || cyc == 20 || cyc == 30);
            @(negedge clk);
        end
        check("pace_first_busy", 256'(first_busy), 256'd1);
        check("pace_busy_len", 256'(bcount), 256'd257);
        check("pace_end_busy", 256'(busy_w[2]), 256'd0);
        check_gen();

        // Grid boundary
        sb.push_back('{3, EDGE_NEXT, 16'd1, "edge"});
        tick(3);
        wait_idle(3);
        check_gen();

        // Asynchronous reset in the middle of a scan
        sb.push_back('{1, HORIZ, 16'd1, "blink_post_rs"});
        tick(1);
        wait_idle(1);
        check_gen();
        tick(1);
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 256'(busy_w[1]), 256'd0);
        check("arst_gen_blk", 256'(gen_w[1]), 256'd0);
        check("arst_gen_pace", 256'(gen_w[2]), 256'd0);
        read_grids();
        check("arst_grid", g[1], BLINK);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
